// File: rtl/core_pkg.sv
// Shared widths, defaults and the write-request record used around the
// register-file write port.
package core_pkg;

    localparam int XLEN             = 32;
    localparam int REG_IDX_W        = 5;
    localparam int NUM_REGS         = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wr_req_t;

    function automatic logic idx_nz(input logic [REG_IDX_W-1:0] idx);
        return idx != '0;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Busy bits for destinations with outstanding long-latency writes, plus the
// three-index decode hazard query.
module wb_scoreboard
    import core_pkg::*;
#(
    parameter int NUM_REGS = core_pkg::NUM_REGS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_i,
    input  logic [REG_IDX_W-1:0] set_rd_i,
    input  logic                 clr_i,
    input  logic [REG_IDX_W-1:0] clr_rd_i,
    input  logic [REG_IDX_W-1:0] q_rs1_i,
    input  logic [REG_IDX_W-1:0] q_rs2_i,
    input  logic [REG_IDX_W-1:0] q_rd_i,
    output logic                 hazard_o,
    output logic [NUM_REGS-1:0]  busy_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    // Set is applied after clear so a re-issue in the retire cycle stays busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_rd_i] = 1'b0;
        end
        if (set_i && idx_nz(set_rd_i)) begin
            busy_d[set_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign hazard_o = (idx_nz(q_rs1_i) && busy_q[q_rs1_i]) ||
                      (idx_nz(q_rs2_i) && busy_q[q_rs2_i]) ||
                      (idx_nz(q_rd_i)  && busy_q[q_rd_i]);

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_write_scheduler.sv
// Single register-file write port shared by in-order writeback (A) and a
// one-entry skid buffer of long-latency results (B), with anti-starvation.
module regfile_write_scheduler
    import core_pkg::*;
#(
    parameter int XLEN         = core_pkg::XLEN,
    parameter int NUM_REGS     = core_pkg::NUM_REGS,
    parameter int STARVE_LIMIT = core_pkg::STARVE_LIMIT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic [REG_IDX_W-1:0] a_rd,
    input  logic [XLEN-1:0]      a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [REG_IDX_W-1:0] b_rd,
    input  logic [XLEN-1:0]      b_data,
    output logic                 b_ready,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [REG_IDX_W-1:0] q_rs1,
    input  logic [REG_IDX_W-1:0] q_rs2,
    input  logic [REG_IDX_W-1:0] q_rd,
    output logic                 hazard,
    output logic                 rf_write_enable,
    output logic [REG_IDX_W-1:0] rf_rd_index,
    output logic [XLEN-1:0]      rf_write_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic                 buf_valid_q, buf_valid_d;
    logic [REG_IDX_W-1:0] buf_rd_q, buf_rd_d;
    logic [XLEN-1:0]      buf_data_q, buf_data_d;
    logic [CNT_W-1:0]     starve_q, starve_d;

    logic                 starve_hit;
    logic                 grant_a, grant_b;
    logic                 sb_hazard;
    logic [NUM_REGS-1:0]  busy_vec;

    // Once the buffered result has lost STARVE_LIMIT times it wins and A stalls.
    assign starve_hit = buf_valid_q && (starve_q >= CNT_W'(STARVE_LIMIT));
    assign grant_a    = !rst && a_valid && !starve_hit;
    assign grant_b    = !rst && buf_valid_q && (!a_valid || starve_hit);

    assign a_ready = rst || !starve_hit;
    assign b_ready = rst || !buf_valid_q;
    assign hazard  = !rst && sb_hazard;

    always_comb begin
        rf_write_enable = grant_a || grant_b;
        rf_rd_index     = '0;
        rf_write_data   = '0;
        if (grant_a) begin
            rf_rd_index   = a_rd;
            rf_write_data = a_data;
        end else if (grant_b) begin
            rf_rd_index   = buf_rd_q;
            rf_write_data = buf_data_q;
        end
    end

    // Drain and capture are exclusive: capture only happens into an empty buffer.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_rd_d    = buf_rd_q;
        buf_data_d  = buf_data_q;
        if (grant_b) begin
            buf_valid_d = 1'b0;
        end else if (b_valid && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_rd_d    = b_rd;
            buf_data_d  = b_data;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!buf_valid_q || grant_b) begin
            starve_d = '0;
        end else if (grant_a && (starve_q < CNT_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_rd_q    <= '0;
            buf_data_q  <= '0;
            starve_q    <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_rd_q    <= buf_rd_d;
            buf_data_q  <= buf_data_d;
            starve_q    <= starve_d;
        end
    end

    wb_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_i    (issue_valid),
        .set_rd_i (issue_rd),
        .clr_i    (grant_b),
        .clr_rd_i (buf_rd_q),
        .q_rs1_i  (q_rs1),
        .q_rs2_i  (q_rs2),
        .q_rd_i   (q_rd),
        .hazard_o (sb_hazard),
        .busy_o   (busy_vec)
    );

    // A long-latency result must target a register that was issued and is still busy.
    b_ret_busy: assert property (@(posedge clk) disable iff (rst)
        (b_valid && b_ready && idx_nz(b_rd)) |-> busy_vec[b_rd]);

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed vector table plus randomized traffic against a behavioural model
// of the write-port scheduler.
module tb_regfile_write_scheduler;
    import core_pkg::*;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, issue_valid;
    logic [4:0]  a_rd, b_rd, issue_rd, q_rs1, q_rs2, q_rd;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready, hazard, rf_write_enable;
    logic [4:0]  rf_rd_index;
    logic [31:0] rf_write_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_write_scheduler #(
        .XLEN(32), .NUM_REGS(32), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .hazard(hazard),
        .rf_write_enable(rf_write_enable), .rf_rd_index(rf_rd_index),
        .rf_write_data(rf_write_data)
    );

    typedef struct {
        logic        av; logic [4:0] ard; logic [31:0] ad;
        logic        bv; logic [4:0] brd; logic [31:0] bd;
        logic        iv; logic [4:0] ird;
        logic [4:0]  q1, q2, qd;
        logic        we; logic [4:0] idx; logic [31:0] wd;
        logic        ar, br, hz;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic bv, input logic [4:0] brd, input logic [31:0] bd,
        input logic iv, input logic [4:0] ird,
        input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] qd,
        input logic we, input logic [4:0] idx, input logic [31:0] wd,
        input logic ar, input logic br, input logic hz);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.bv = bv; v.brd = brd; v.bd = bd;
        v.iv = iv; v.ird = ird; v.q1 = q1; v.q2 = q2; v.qd = qd;
        v.we = we; v.idx = idx; v.wd = wd; v.ar = ar; v.br = br; v.hz = hz;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        a_valid = v.av; a_rd = v.ard; a_data = v.ad;
        b_valid = v.bv; b_rd = v.brd; b_data = v.bd;
        issue_valid = v.iv; issue_rd = v.ird;
        q_rs1 = v.q1; q_rs2 = v.q2; q_rd = v.qd;
    endtask

    task automatic check_outs(input string tag, input logic we, input logic [4:0] idx,
                              input logic [31:0] wd, input logic ar, input logic br,
                              input logic hz);
        chk({tag, ".we"},     rf_write_enable, we);
        chk({tag, ".idx"},    rf_rd_index, idx);
        chk({tag, ".data"},   rf_write_data, wd);
        chk({tag, ".a_ready"}, a_ready, ar);
        chk({tag, ".b_ready"}, b_ready, br);
        chk({tag, ".hazard"}, hazard, hz);
    endtask

    // Behavioural model state
    bit          m_busy[32];
    bit          m_bv;
    logic [4:0]  m_brd;
    logic [31:0] m_bd;
    int          m_lost;
    int          pend[$];

    function automatic bit in_pend(input logic [4:0] r);
        foreach (pend[i]) if (pend[i] == int'(r)) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        vec_t idle;
        logic hold_a;
        idle = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 1,1,0);

        // Reset: writeback and issue are both ignored while rst is high.
        rst = 1'b1;
        drive(mk(1,5'd1,32'h1234, 0,0,0, 1,5'd5, 5'd5,0,0, 0,0,0,1,1,0));
        @(posedge clk);
        @(negedge clk);
        check_outs("reset0", 0, 0, 0, 1, 1, 0);
        @(posedge clk);
        @(negedge clk);
        check_outs("reset1", 0, 0, 0, 1, 1, 0);
        @(posedge clk);

        //         av ard ad         bv brd bd            iv ird  q1 q2 qd  we idx wd          ar br hz
        tbl.push_back(mk(0,0,0,          0,0,0,           0,0,   5,0,0,  0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,          0,0,0,           1,7,   0,0,0,  0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,          0,0,0,           0,0,   7,0,0,  0,0,0,            1,1,1));
        tbl.push_back(mk(0,0,0,          1,7,32'hDEADBEEF,0,0,   7,0,0,  0,0,0,            1,1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,           0,0,   7,0,0,  1,7,32'hDEADBEEF, 1,0,1));
        tbl.push_back(mk(0,0,0,          0,0,0,           0,0,   7,0,0,  0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,          0,0,0,           1,9,   0,0,0,  0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,          1,9,32'h99,      0,0,   0,0,0,  0,0,0,            1,1,0));
        tbl.push_back(mk(1,1,32'h11,     0,0,0,           0,0,   0,0,0,  1,1,32'h11,       1,0,0));
        tbl.push_back(mk(1,2,32'h22,     0,0,0,           0,0,   0,0,0,  1,2,32'h22,       1,0,0));
        tbl.push_back(mk(1,3,32'h33,     0,0,0,           0,0,   0,0,0,  1,3,32'h33,       1,0,0));
        tbl.push_back(mk(1,4,32'h44,     0,0,0,           0,0,   0,0,0,  1,4,32'h44,       1,0,0));
        tbl.push_back(mk(1,5,32'h55,     0,0,0,           0,0,   9,0,0,  1,9,32'h99,       0,0,1));
        tbl.push_back(mk(1,5,32'h55,     0,0,0,           0,0,   9,0,0,  1,5,32'h55,       1,1,0));
        tbl.push_back(mk(0,0,0,          0,0,0,           1,3,   0,0,0,  0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,          1,3,32'h333,     1,4,   0,0,0,  0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,          1,4,32'h444,     0,0,   0,0,0,  1,3,32'h333,      1,0,0));
        tbl.push_back(mk(0,0,0,          1,4,32'h444,     0,0,   0,0,0,  0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,          0,0,0,           0,0,   0,0,0,  1,4,32'h444,      1,0,0));
        tbl.push_back(mk(0,0,0,          0,0,0,           0,0,   3,4,0,  0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,          0,0,0,           1,6,   0,0,0,  0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,          1,6,32'h666,     0,0,   0,0,0,  0,0,0,            1,1,0));
        tbl.push_back(mk(0,0,0,          0,0,0,           1,6,   0,6,0,  1,6,32'h666,      1,0,1));
        tbl.push_back(mk(0,0,0,          0,0,0,           0,0,   0,6,0,  0,0,0,            1,1,1));
        tbl.push_back(mk(0,0,0,          0,0,0,           1,0,   0,0,0,  0,0,0,            1,1,0));
        tbl.push_back(mk(1,0,32'hABC,    0,0,0,           0,0,   0,0,0,  1,0,32'hABC,      1,1,0));
        tbl.push_back(mk(0,0,0,          0,0,0,           0,0,   0,0,6,  0,0,0,            1,1,1));

        for (int i = 0; i < tbl.size(); i++) begin
            #1;
            rst = 1'b0;
            drive(tbl[i]);
            @(negedge clk);
            check_outs($sformatf("row%0d", i), tbl[i].we, tbl[i].idx, tbl[i].wd,
                       tbl[i].ar, tbl[i].br, tbl[i].hz);
            @(posedge clk);
        end

        // Randomized traffic: reset both DUT and model first.
        #1;
        rst = 1'b1;
        drive(idle);
        @(posedge clk);
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_bv = 1'b0; m_brd = '0; m_bd = '0; m_lost = 0;
        pend.delete();
        hold_a = 1'b0;
        a_valid = 1'b0; a_rd = '0; a_data = '0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            bit    forced, gA, gB, e_hz, accept;
            logic  e_we;
            logic [4:0]  e_idx;
            logic [31:0] e_wd;
            #1;
            rst = 1'b0;
            if (!hold_a) begin
                a_valid = 1'($urandom_range(0, 1));
                a_rd    = 5'($urandom);
                a_data  = $urandom;
            end
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                b_valid = 1'b1;
                b_rd    = 5'(pend[0]);
            end else begin
                b_valid = 1'b0;
                b_rd    = 5'($urandom);
            end
            b_data = $urandom;
            issue_rd    = 5'($urandom);
            issue_valid = ($urandom_range(0, 3) == 0);
            if (issue_rd != 0 && (m_busy[issue_rd] || in_pend(issue_rd)))
                issue_valid = 1'b0;
            q_rs1 = 5'($urandom); q_rs2 = 5'($urandom); q_rd = 5'($urandom);

            forced = m_bv && (m_lost >= LIM);
            gA = a_valid && !forced;
            gB = m_bv && !gA;
            e_we = gA || gB;
            e_idx = gA ? a_rd : (gB ? m_brd : 5'd0);
            e_wd  = gA ? a_data : (gB ? m_bd : 32'd0);
            e_hz = (q_rs1 != 0 && m_busy[q_rs1]) || (q_rs2 != 0 && m_busy[q_rs2]) ||
                   (q_rd != 0 && m_busy[q_rd]);

            @(negedge clk);
            check_outs($sformatf("rnd%0d", cyc), e_we, e_idx, e_wd, !forced, !m_bv, e_hz);

            accept = b_valid && !m_bv;
            if (gB) begin
                m_busy[m_brd] = 1'b0;
                m_bv = 1'b0;
                m_lost = 0;
            end else if (m_bv) begin
                m_lost = m_lost + 1;
            end
            if (accept) begin
                m_bv = 1'b1; m_brd = b_rd; m_bd = b_data; m_lost = 0;
                void'(pend.pop_front());
            end
            if (issue_valid && issue_rd != 0) begin
                m_busy[issue_rd] = 1'b1;
                pend.push_back(int'(issue_rd));
            end
            hold_a = a_valid && forced;
            @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
